// File: rtl/qsys_sc_tei0026_nios2_ocimem_pkg.sv
// Shared types and jdo field positions for the Nios II debug monitor memory controller.
package qsys_sc_tei0026_nios2_ocimem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_J_RD0,
        ST_J_RD1,
        ST_J_WR,
        ST_C_RD0,
        ST_C_RD1
    } ocimem_state_t;

    typedef enum logic [1:0] {CMD_RD, CMD_WR, CMD_ADDR} ocimem_cmd_t;

    localparam int JDO_W        = 38;
    localparam int JDO_RD_BIT   = 35;
    localparam int JDO_CLR_BIT  = 36;
    localparam int JDO_ADDR_LSB = 10;
    localparam int JDO_DATA_LSB = 3;

    // The address field sits inside the data field, so one captured data word carries both.
    localparam int DATA_ADDR_OFS = JDO_ADDR_LSB - JDO_DATA_LSB;

    typedef struct packed {
        ocimem_cmd_t kind;
        logic        rd;
        logic        clr;
        logic [31:0] data;
    } jtag_cmd_t;

endpackage

// File: rtl/qsys_sc_tei0026_nios2_cpu_debug_ocimem_ram.sv
// Single-port monitor RAM: byte-enable write, registered one-cycle read.
module qsys_sc_tei0026_nios2_cpu_debug_ocimem_ram #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        byteen,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (byteen[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/qsys_sc_tei0026_nios2_cpu_debug_ocimem_ctrl.sv
// Debug monitor memory controller: JTAG command execution plus Avalon-MM CPU port
// sharing one single-port monitor RAM, JTAG having priority over new CPU requests.
//
// state    | meaning
// ST_IDLE  | waiting; executes pending/live JTAG command, else accepts CPU access
// ST_J_RD0 | JTAG read address presented to RAM
// ST_J_RD1 | RAM data valid, loaded into MonDReg on exit
// ST_J_WR  | JTAG write of MonDReg at MonAReg, then address increment
// ST_C_RD0 | CPU read data returning from RAM
// ST_C_RD1 | avs_readdata valid, waitrequest low
module qsys_sc_tei0026_nios2_cpu_debug_ocimem_ctrl
    import qsys_sc_tei0026_nios2_ocimem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [DATA_W-1:0] avs_writedata,
    input  logic [3:0]        avs_byteenable,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              avs_waitrequest,
    output logic [DATA_W-1:0] MonDReg,
    output logic              jtag_busy,
    output logic              cmd_overrun
);

    ocimem_state_t     state;
    logic [ADDR_W-1:0] mon_a_reg;
    logic              pend_valid;
    jtag_cmd_t         pend_cmd;

    jtag_cmd_t         live_cmd;
    jtag_cmd_t         exec_cmd;
    logic              live_valid;
    logic              live_multi;
    logic              jtag_req;
    logic              cpu_wr_accept;
    logic              cpu_rd_start;
    logic [ADDR_W-1:0] ram_addr;
    logic [3:0]        ram_be;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    logic              jdo_unused;

    assign jdo_unused = ^{jdo[JDO_W-1], jdo[JDO_DATA_LSB-1:0]};

    always_comb begin
        live_valid    = take_action_ocimem_b | take_action_ocimem_a | take_no_action_ocimem_a;
        live_multi    = (take_action_ocimem_b & take_action_ocimem_a)
                      | (take_action_ocimem_b & take_no_action_ocimem_a)
                      | (take_action_ocimem_a & take_no_action_ocimem_a);
        live_cmd.kind = take_action_ocimem_b ? CMD_WR :
                        (take_action_ocimem_a ? CMD_ADDR : CMD_RD);
        live_cmd.rd   = jdo[JDO_RD_BIT];
        live_cmd.clr  = jdo[JDO_CLR_BIT];
        live_cmd.data = jdo[JDO_DATA_LSB +: DATA_W];
        exec_cmd      = pend_valid ? pend_cmd : live_cmd;
        jtag_req      = pend_valid | live_valid;
        cpu_wr_accept = (state == ST_IDLE) && !jtag_req && avs_write && !avs_read;
        cpu_rd_start  = (state == ST_IDLE) && !jtag_req && avs_read;
    end

    always_comb begin
        ram_addr  = avs_address;
        ram_be    = 4'h0;
        ram_wdata = avs_writedata;
        case (state)
            ST_J_RD0: ram_addr = mon_a_reg;
            ST_J_WR: begin
                ram_addr  = mon_a_reg;
                ram_be    = 4'hF;
                ram_wdata = MonDReg;
            end
            default: if (cpu_wr_accept) ram_be = avs_byteenable;
        endcase
    end

    always_comb begin
        avs_waitrequest = 1'b1;
        if (!reset) begin
            case (state)
                ST_C_RD1: avs_waitrequest = 1'b0;
                ST_C_RD0: avs_waitrequest = 1'b1;
                default:  avs_waitrequest = (avs_read | avs_write) & !cpu_wr_accept;
            endcase
        end
    end

    assign jtag_busy = pend_valid | (state == ST_J_RD0) | (state == ST_J_RD1) | (state == ST_J_WR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            pend_valid   <= 1'b0;
            pend_cmd     <= '0;
            mon_a_reg    <= '0;
            MonDReg      <= '0;
            avs_readdata <= '0;
            cmd_overrun  <= 1'b0;
        end else begin
            // In IDLE the pending slot is consumed this cycle, so a live pulse may refill it.
            if (state == ST_IDLE) begin
                if (pend_valid) begin
                    pend_valid <= live_valid;
                    pend_cmd   <= live_cmd;
                end
            end else if (live_valid && !pend_valid) begin
                pend_valid <= 1'b1;
                pend_cmd   <= live_cmd;
            end

            case (state)
                ST_IDLE: begin
                    if (jtag_req) begin
                        case (exec_cmd.kind)
                            CMD_ADDR: begin
                                mon_a_reg <= exec_cmd.data[DATA_ADDR_OFS +: ADDR_W];
                                if (exec_cmd.clr) cmd_overrun <= 1'b0;
                                if (exec_cmd.rd) state <= ST_J_RD0;
                            end
                            CMD_RD: begin
                                mon_a_reg <= mon_a_reg + 1'b1;
                                state     <= ST_J_RD0;
                            end
                            default: begin
                                MonDReg <= exec_cmd.data;
                                state   <= ST_J_WR;
                            end
                        endcase
                    end else if (cpu_rd_start) begin
                        state <= ST_C_RD0;
                    end
                end
                ST_J_RD0: state <= ST_J_RD1;
                ST_J_RD1: begin
                    MonDReg <= ram_rdata;
                    state   <= ST_IDLE;
                end
                ST_J_WR: begin
                    mon_a_reg <= mon_a_reg + 1'b1;
                    state     <= ST_IDLE;
                end
                ST_C_RD0: begin
                    avs_readdata <= ram_rdata;
                    state        <= ST_C_RD1;
                end
                default: state <= ST_IDLE;
            endcase

            // A drop in the same cycle as a clear still leaves the flag set.
            if (live_multi || (state != ST_IDLE && pend_valid && live_valid)) begin
                cmd_overrun <= 1'b1;
            end
        end
    end

    qsys_sc_tei0026_nios2_cpu_debug_ocimem_ram #(
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk    (clk),
        .addr   (ram_addr),
        .byteen (ram_be),
        .wdata  (ram_wdata),
        .rdata  (ram_rdata)
    );

endmodule

// File: tb/tb_qsys_sc_tei0026_nios2_cpu_debug_ocimem_ctrl.sv
// Self-checking bench: directed scenarios plus randomized JTAG/CPU traffic against a
// transaction-level model of the monitor RAM, MonAReg, MonDReg and the overrun flag.
module tb_qsys_sc_tei0026_nios2_cpu_debug_ocimem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [37:0] jdo;
    logic        take_a, take_n, take_b;
    logic [7:0]  avs_address;
    logic        avs_read, avs_write;
    logic [31:0] avs_writedata;
    logic [3:0]  avs_byteenable;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic [31:0] MonDReg;
    logic        jtag_busy;
    logic        cmd_overrun;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] ref_mem [256];
    logic [7:0]  ref_mon_a;
    logic [31:0] ref_mon_d;
    logic        ref_overrun;

    always #5 clk = ~clk;

    qsys_sc_tei0026_nios2_cpu_debug_ocimem_ctrl #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_a),
        .take_no_action_ocimem_a (take_n),
        .take_action_ocimem_b    (take_b),
        .avs_address             (avs_address),
        .avs_read                (avs_read),
        .avs_write               (avs_write),
        .avs_writedata           (avs_writedata),
        .avs_byteenable          (avs_byteenable),
        .avs_readdata            (avs_readdata),
        .avs_waitrequest         (avs_waitrequest),
        .MonDReg                 (MonDReg),
        .jtag_busy               (jtag_busy),
        .cmd_overrun             (cmd_overrun)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [37:0] jdo_a(input logic [7:0] addr, input logic rd, input logic clr);
        logic [37:0] w;
        w = {6'($urandom), $urandom};
        w[35] = rd;
        w[36] = clr;
        w[17:10] = addr;
        return w;
    endfunction

    function automatic logic [37:0] jdo_b(input logic [31:0] data);
        logic [37:0] w;
        w = {6'($urandom), $urandom};
        w[34:3] = data;
        return w;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] m;
        m = old;
        for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = nw[8*i +: 8];
        return m;
    endfunction

    // All tasks start and end on a falling edge.
    task automatic pulse(input logic a, input logic n, input logic b, input logic [37:0] w);
        jdo = w; take_a = a; take_n = n; take_b = b;
        @(negedge clk);
        take_a = 1'b0; take_n = 1'b0; take_b = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int cyc = 0;
        while (jtag_busy && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check_eq(tag, jtag_busy, 1'b0);
    endtask

    task automatic jtag_a(input logic [7:0] addr, input logic rd, input logic clr);
        pulse(1'b1, 1'b0, 1'b0, jdo_a(addr, rd, clr));
        ref_mon_a = addr;
        if (clr) ref_overrun = 1'b0;
        if (rd) ref_mon_d = ref_mem[addr];
        wait_idle("jtag_a_idle");
        check_eq("jtag_a_mondreg", MonDReg, ref_mon_d);
        check_eq("jtag_a_overrun", cmd_overrun, ref_overrun);
    endtask

    task automatic jtag_n();
        pulse(1'b0, 1'b1, 1'b0, {6'($urandom), $urandom});
        ref_mon_a++;
        ref_mon_d = ref_mem[ref_mon_a];
        wait_idle("jtag_n_idle");
        check_eq("jtag_n_mondreg", MonDReg, ref_mon_d);
    endtask

    task automatic jtag_b(input logic [31:0] data);
        pulse(1'b0, 1'b0, 1'b1, jdo_b(data));
        ref_mon_d = data;
        ref_mem[ref_mon_a] = data;
        ref_mon_a++;
        wait_idle("jtag_b_idle");
        check_eq("jtag_b_mondreg", MonDReg, ref_mon_d);
    endtask

    task automatic cpu_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] be,
                             output int waits);
        avs_address = addr; avs_writedata = data; avs_byteenable = be; avs_write = 1'b1;
        waits = 0;
        #1;
        while (avs_waitrequest && waits < 20) begin
            @(negedge clk); #1;
            waits++;
        end
        check_eq("cpu_wr_accept", avs_waitrequest, 1'b0);
        @(negedge clk);
        avs_write = 1'b0;
        ref_mem[addr] = merge(ref_mem[addr], data, be);
    endtask

    task automatic cpu_read_check(input logic [7:0] addr);
        int lat = 0;
        logic [31:0] d;
        avs_address = addr; avs_read = 1'b1;
        #1;
        while (avs_waitrequest && lat < 20) begin
            @(negedge clk); #1;
            lat++;
        end
        d = avs_readdata;
        @(negedge clk);
        avs_read = 1'b0;
        check_eq("cpu_rd_data", d, ref_mem[addr]);
        check_eq("cpu_rd_latency", lat, 2);
    endtask

    initial begin
        int w;
        logic [31:0] x, y;
        logic [37:0] jw;

        reset = 1'b1; jdo = '0; take_a = 0; take_n = 0; take_b = 0;
        avs_address = '0; avs_read = 0; avs_write = 0; avs_writedata = '0; avs_byteenable = '0;
        ref_mon_a = '0; ref_mon_d = '0; ref_overrun = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("rst_waitreq_high", avs_waitrequest, 1'b1);
        reset = 1'b0;
        #1;
        check_eq("rst_mondreg", MonDReg, 32'h0);
        check_eq("rst_readdata", avs_readdata, 32'h0);
        check_eq("rst_busy", jtag_busy, 1'b0);
        check_eq("rst_overrun", cmd_overrun, 1'b0);
        check_eq("rst_waitreq_low", avs_waitrequest, 1'b0);
        @(negedge clk);

        for (int i = 0; i < 256; i++) cpu_write(8'(i), $urandom, 4'hF, w);

        // JTAG round trip
        jtag_a(8'h10, 1'b0, 1'b0);
        jtag_b(32'hDEADBEEF);
        jtag_b(32'hCAFEF00D);
        cpu_read_check(8'h10);
        cpu_read_check(8'h11);
        jtag_a(8'h40, 1'b1, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, jdo_a(8'h10, 1'b1, 1'b0));
        check_eq("rt_lat_e0", MonDReg, ref_mem[8'h40]);
        @(negedge clk);
        check_eq("rt_lat_e1", MonDReg, ref_mem[8'h40]);
        @(negedge clk);
        check_eq("rt_lat_e2", MonDReg, 32'hDEADBEEF);
        ref_mon_a = 8'h10; ref_mon_d = 32'hDEADBEEF;
        wait_idle("rt_idle");

        // Address wrap
        jtag_a(8'hFF, 1'b1, 1'b0);
        jtag_n();
        check_eq("wrap_overrun", cmd_overrun, 1'b0);

        // CPU byte-lane write and readback
        cpu_write(8'h20, 32'h12345678, 4'b0011, w);
        check_eq("cpu_wr_waits", w, 0);
        cpu_read_check(8'h20);

        // JTAG write colliding with CPU write to the same word
        jtag_a(8'h30, 1'b0, 1'b0);
        x = $urandom; y = $urandom;
        jdo = jdo_b(x); take_b = 1'b1;
        avs_address = 8'h30; avs_writedata = y; avs_byteenable = 4'b0001; avs_write = 1'b1;
        #1;
        check_eq("collide_waitreq", avs_waitrequest, 1'b1);
        @(negedge clk);
        take_b = 1'b0;
        w = 1;
        #1;
        while (avs_waitrequest && w < 20) begin
            @(negedge clk); #1;
            w++;
        end
        check_eq("collide_accept", avs_waitrequest, 1'b0);
        @(negedge clk);
        avs_write = 1'b0;
        ref_mem[8'h30] = merge(x, y, 4'b0001);
        ref_mon_a = 8'h31; ref_mon_d = x;
        wait_idle("collide_idle");
        check_eq("collide_mondreg", MonDReg, x);
        cpu_read_check(8'h30);
        jtag_n();

        // Overrun: second pulse during a busy read is dropped
        pulse(1'b1, 1'b0, 1'b0, jdo_a(8'h50, 1'b1, 1'b0));
        pulse(1'b0, 1'b1, 1'b0, {6'($urandom), $urandom});
        pulse(1'b0, 1'b1, 1'b0, {6'($urandom), $urandom});
        check_eq("ovr_pending_busy", jtag_busy, 1'b1);
        ref_mon_a = 8'h51; ref_mon_d = ref_mem[8'h51]; ref_overrun = 1'b1;
        wait_idle("ovr_idle");
        check_eq("ovr_mondreg", MonDReg, ref_mon_d);
        check_eq("ovr_flag", cmd_overrun, 1'b1);
        jtag_a(8'h00, 1'b0, 1'b1);

        // Simultaneous pulses: priority b > a > no_action
        pulse(1'b1, 1'b1, 1'b0, jdo_a(8'h77, 1'b1, 1'b0));
        ref_mon_a = 8'h77; ref_mon_d = ref_mem[8'h77]; ref_overrun = 1'b1;
        wait_idle("sim_an_idle");
        check_eq("sim_an_mondreg", MonDReg, ref_mon_d);
        check_eq("sim_an_overrun", cmd_overrun, 1'b1);
        x = $urandom;
        jw = jdo_b(x);
        jw[35] = 1'b1; jw[36] = 1'b1;
        pulse(1'b1, 1'b0, 1'b1, jw);
        ref_mem[ref_mon_a] = x; ref_mon_a++; ref_mon_d = x;
        wait_idle("sim_ab_idle");
        check_eq("sim_ab_mondreg", MonDReg, x);
        check_eq("sim_ab_overrun", cmd_overrun, 1'b1);
        cpu_read_check(8'h77);
        jtag_a(8'h00, 1'b0, 1'b1);

        // Randomized mixed traffic
        for (int k = 0; k < 80; k++) begin
            case ($urandom_range(0, 4))
                0: jtag_a(8'($urandom), 1'($urandom), 1'b0);
                1: jtag_n();
                2: jtag_b($urandom);
                3: begin
                    cpu_write(8'($urandom), $urandom, 4'($urandom), w);
                    check_eq("rnd_wr_waits", w, 0);
                end
                default: cpu_read_check(8'($urandom));
            endcase
        end
        check_eq("rnd_overrun", cmd_overrun, 1'b0);

        // Reset during J_RD1
        cpu_write(8'h60, $urandom, 4'hF, w);
        pulse(1'b1, 1'b1, 1'b0, jdo_a(8'h61, 1'b0, 1'b0));
        check_eq("prerst_overrun", cmd_overrun, 1'b1);
        pulse(1'b1, 1'b0, 1'b0, jdo_a(8'h61, 1'b1, 1'b0));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("midrst_mondreg", MonDReg, 32'h0);
        check_eq("midrst_busy", jtag_busy, 1'b0);
        check_eq("midrst_overrun", cmd_overrun, 1'b0);
        check_eq("midrst_readdata", avs_readdata, 32'h0);
        check_eq("midrst_waitreq", avs_waitrequest, 1'b0);
        @(negedge clk);
        ref_mon_a = 8'h00; ref_mon_d = 32'h0; ref_overrun = 1'b0;
        cpu_read_check(8'h60);
        jtag_n();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
